// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    // addi x0,x0,0 -- returned whenever there is no valid word to fetch
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE
    } load_state_t;

    // byte position inside a 32-bit little-endian word
    typedef logic [1:0] lane_t;
    localparam lane_t LAST_LANE = 2'd3;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid one clock after raddr; read-first on collision.
// Backpressure: none, both ports accept every cycle.
//
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata registered read data.
// No reset on the array or the read register so that it maps onto block RAM.
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Read samples the array before the same-edge write lands: old data on collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with fetch read port and byte-stream program loader.
// Latency: fetch data/addr_fault one clock after mem_addr; stop one clock after load_start.
// Backpressure: load_ready low outside LEN/DATA(/CSUM); bytes offered then are dropped.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_addr -> data, addr_fault      fetch side, registered read
//   load_start, load_valid, load_byte  loader input stream (little-endian)
//   load_ready, stop, load_busy, load_overflow, load_done  loader status
//   csum_err                           only when IMEM_CHECKSUM_EN is defined
//
// Optional feature macro: IMEM_CHECKSUM_EN adds a trailing checksum byte and csum_err.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH = 1024,
    parameter int          AW    = $clog2(DEPTH),
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    output logic [31:0] data,
    output logic        addr_fault,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        stop,
    output logic        load_busy,
    output logic        load_overflow,
    output logic        load_done
`ifdef IMEM_CHECKSUM_EN
    , output logic      csum_err
`endif
);

    // ---------------- fetch side ----------------
    logic [31:0]   off;
    logic          rd_fault;
    logic [AW-1:0] raddr;
    logic [31:0]   ram_rdata;
    logic          rd_vld_q;
    logic          fault_q;

    // Subtraction wraps addresses below BASE to huge offsets, so one
    // unsigned compare covers both ends of the window.
    assign off      = mem_addr - BASE;
    assign rd_fault = (off[1:0] != 2'b00) || (off[31:2] >= 30'(DEPTH));
    assign raddr    = off[AW+1:2];

    // rd_vld_q keeps data at NOP until the first read after reset completes,
    // since the RAM read register itself is not reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            rd_vld_q <= 1'b1;
            fault_q  <= rd_fault;
        end
    end

    assign data       = (rd_vld_q && !fault_q) ? ram_rdata : NOP_INSN;
    assign addr_fault = fault_q;

    // ---------------- loader FSM ----------------
    load_state_t state_q, state_d;
    lane_t       lane_q;
    logic [31:0] shift_q;
    logic [31:0] len_q;
    logic [31:0] widx_q;
    logic        ovf_q;
    logic [31:0] asm_word;
    logic        last_lane;
    logic        in_range;
    logic        last_word;
    logic        ram_we;
    logic        take;

`ifdef IMEM_CHECKSUM_EN
    localparam load_state_t POST_DATA = CSUM;
    logic [7:0] sum_q;
    logic       csum_err_q;
`else
    localparam load_state_t POST_DATA = DONE;
`endif

    // Bytes shift in from the top, so after four bytes the first one sits in [7:0].
    assign asm_word  = {load_byte, shift_q[31:8]};
    assign last_lane = (lane_q == LAST_LANE);
    assign in_range  = (widx_q < 32'(DEPTH));
    assign last_word = ((widx_q + 32'd1) == len_q);
    assign take      = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        ram_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LEN;
            end
            LEN: begin
                load_ready = 1'b1;
                if (load_valid && last_lane) begin
                    state_d = (asm_word == 32'd0) ? POST_DATA : DATA;
                end
            end
            DATA: begin
                load_ready = 1'b1;
                if (load_valid && last_lane) begin
                    // words past the end of the array are consumed but not stored
                    ram_we = in_range;
                    if (last_word) state_d = POST_DATA;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            CSUM: begin
                load_ready = 1'b1;
                if (load_valid) state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            widx_q     <= '0;
            ovf_q      <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q      <= '0;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && load_start) begin
                lane_q <= '0;
                widx_q <= '0;
                ovf_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                sum_q  <= '0;
`endif
            end
            if (take) begin
                shift_q <= asm_word;
                lane_q  <= lane_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                // the checksum byte is folded in too; a good stream sums to zero
                sum_q   <= sum_q + load_byte;
`endif
                if (state_q == LEN && last_lane) begin
                    len_q <= asm_word;
                end
                if (state_q == DATA && last_lane) begin
                    widx_q <= widx_q + 32'd1;
                    if (!in_range) ovf_q <= 1'b1;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            if (state_q == DONE) begin
                csum_err_q <= (sum_q != 8'h00);
            end
`endif
        end
    end

    assign load_busy     = (state_q != IDLE);
    assign stop          = load_busy;
    assign load_done     = (state_q == DONE);
    assign load_overflow = ovf_q;
`ifdef IMEM_CHECKSUM_EN
    assign csum_err      = csum_err_q;
`endif

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (widx_q[AW-1:0]),
        .wdata (asm_word),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (DEPTH=4 so overflow is reachable).
// Latency: checks fetch results one clock after the address, status every cycle.
// Backpressure: loader bytes driven back-to-back; junk offered while not ready.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] BASE_TB = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] data;
    logic        addr_fault;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        stop;
    logic        load_busy;
    logic        load_overflow;
    logic        load_done;
`ifdef IMEM_CHECKSUM_EN
    logic        csum_err;
`endif

    imem_loader #(
        .DEPTH (DEPTH),
        .BASE  (BASE_TB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .data          (data),
        .addr_fault    (addr_fault),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_ready    (load_ready),
        .stop          (stop),
        .load_busy     (load_busy),
        .load_overflow (load_overflow),
        .load_done     (load_done)
`ifdef IMEM_CHECKSUM_EN
        , .csum_err    (csum_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected-state model
    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    logic        exp_stop, exp_ready, exp_done, exp_ovf, exp_csum;
    logic        loading;
    logic        auto_fetch;
    logic [31:0] pin_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // fetch address driver: cycles through aligned, misaligned and out-of-range addresses
    initial begin
        logic [31:0] ftab [15];
        int i;
        ftab = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h3, 32'h10, 32'h2, 32'h20,
                 32'h4, 32'hFFFF_FFFC, 32'h1, 32'h0, 32'hC, 32'hD, 32'h10};
        i = 0;
        mem_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_addr = auto_fetch ? ftab[i % 15] : pin_addr;
            i++;
        end
    end

    // compare process: every cycle
    initial begin
        logic [31:0] addr_prev;
        logic        rst_prev, loading_prev, exp_f;
        logic [31:0] off;
        addr_prev = 32'h0;
        rst_prev = 1'b0;
        loading_prev = 1'b0;
        forever begin
            @(negedge clk);
            chk("stop", stop, exp_stop);
            chk("load_busy", load_busy, exp_stop);
            chk("load_ready", load_ready, exp_ready);
            chk("load_done", load_done, exp_done);
            chk("load_overflow", load_overflow, exp_ovf);
`ifdef IMEM_CHECKSUM_EN
            chk("csum_err", csum_err, exp_csum);
`endif
            if (!reset || !rst_prev) begin
                chk("rst_data", data, NOP_INSN);
                chk("rst_fault", addr_fault, 1'b0);
            end else begin
                off   = addr_prev - BASE_TB;
                exp_f = (off[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
                chk("addr_fault", addr_fault, exp_f);
                if (exp_f) begin
                    chk("fault_data", data, NOP_INSN);
                end else if (!loading && !loading_prev && known[off >> 2]) begin
                    chk("fetch_data", data, model_mem[off >> 2]);
                end
            end
            addr_prev    = mem_addr;
            rst_prev     = reset;
            loading_prev = loading;
        end
    end

    task automatic pin_fetch(input string nm, input logic [31:0] a,
                             input logic [31:0] ed, input logic ef);
        pin_addr   = a;
        auto_fetch = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        @(negedge clk);
        chk(nm, data, ed);
        chk({nm, "_flt"}, addr_fault, ef);
        auto_fetch = 1'b1;
    endtask

    // Drives one load; bq holds length + data bytes (checksum byte appended when enabled).
    // abort_at >= 0 pulls reset before that byte index is presented.
    task automatic run_load(input bq_t bq_in, input logic [7:0] adj, input int abort_at);
        bq_t         bq;
        logic [31:0] nlen;
        logic [7:0]  s;
        int          tot;
        bq   = bq_in;
        nlen = {bq[3], bq[2], bq[1], bq[0]};
        s    = 8'h00;
        foreach (bq[i]) s = s + bq[i];
`ifdef IMEM_CHECKSUM_EN
        bq.push_back((8'h00 - s) ^ adj);
`endif
        tot = bq.size();
        @(posedge clk);
        #1;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'hA5;  // offered while IDLE: must be dropped
        loading    = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        exp_ovf    = 1'b0;
        exp_ready  = 1'b1;
        exp_stop   = 1'b1;
        for (int k = 0; k < tot; k++) begin
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_stop", stop, 1'b0);
                chk("abort_busy", load_busy, 1'b0);
                exp_stop   = 1'b0;
                exp_ready  = 1'b0;
                exp_done   = 1'b0;
                exp_ovf    = 1'b0;
                exp_csum   = 1'b0;
                load_valid = 1'b0;
                load_start = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset   = 1'b1;
                loading = 1'b0;
                return;
            end
            load_valid = 1'b1;
            load_byte  = bq[k];
            load_start = (k == 2);  // must be ignored outside IDLE
            // word index DEPTH completes with byte 4*DEPTH+7
            exp_ovf    = (nlen > 32'(DEPTH)) && (k >= 4 * DEPTH + 8);
            @(posedge clk);
            #1;
        end
        load_start = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'h5A;  // offered during DONE: must be dropped
        exp_ready  = 1'b0;
        exp_done   = 1'b1;
        exp_ovf    = (nlen > 32'(DEPTH));
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        exp_done   = 1'b0;
        exp_stop   = 1'b0;
        exp_csum   = (adj != 8'h00);
        for (int i = 0; i < DEPTH && 32'(i) < nlen; i++) begin
            model_mem[i] = {bq[4+4*i+3], bq[4+4*i+2], bq[4+4*i+1], bq[4+4*i]};
            known[i]     = 1'b1;
        end
        @(posedge clk);
        #1;
        loading = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bq_t         q;
        logic [31:0] w;
        reset      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        auto_fetch = 1'b1;
        pin_addr   = 32'h0;
        loading    = 1'b0;
        exp_stop   = 1'b0;
        exp_ready  = 1'b0;
        exp_done   = 1'b0;
        exp_ovf    = 1'b0;
        exp_csum   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = 1'b0;
            model_mem[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", data, 32'h0000_0013);
        reset = 1'b1;
        // idle bytes with load_valid while IDLE are dropped
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        repeat (16) @(posedge clk);
        #1;
        load_valid = 1'b0;
        pin_fetch("mis3", 32'h3, 32'h0000_0013, 1'b1);
        pin_fetch("oor16", 32'h10, 32'h0000_0013, 1'b1);

        // two-word program
        q = '{8'h02, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00,
              8'h13, 8'h01, 8'h20, 8'h00};
        run_load(q, 8'h00, -1);
        pin_fetch("fetch4", 32'h4, 32'h0020_0113, 1'b0);
        pin_fetch("fetch0", 32'h0, 32'h0010_0093, 1'b0);
        chk("ovf_small", load_overflow, 1'b0);

        // zero-length load: no writes
        q = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load(q, 8'h00, -1);
        pin_fetch("len0_keep4", 32'h4, 32'h0020_0113, 1'b0);

        // reset in the middle of DATA after 5 bytes
        q = '{8'h02, 8'h00, 8'h00, 8'h00,
              8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h11, 8'h22, 8'h33, 8'h44};
        run_load(q, 8'h00, 5);
        repeat (3) @(posedge clk);
        #1;
        pin_fetch("abort_keep0", 32'h0, 32'h0010_0093, 1'b0);

        // overflow: 6 words into a 4-word array
        q = '{8'h06, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            w = 32'hA0B0_C000 + 32'(i);
            q.push_back(w[7:0]);
            q.push_back(w[15:8]);
            q.push_back(w[23:16]);
            q.push_back(w[31:24]);
        end
        run_load(q, 8'h00, -1);
        chk("ovf_final", load_overflow, 1'b1);
        pin_fetch("ovf_mem3", 32'hC, 32'hA0B0_C003, 1'b0);
        pin_fetch("ovf_mem0", 32'h0, 32'hA0B0_C000, 1'b0);

`ifdef IMEM_CHECKSUM_EN
        q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        run_load(q, 8'h00, -1);
        chk("csum_good", csum_err, 1'b0);
        run_load(q, 8'h01, -1);
        chk("csum_bad", csum_err, 1'b1);
`endif

        repeat (20) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
